// File: rtl/laser_rx_sampler.sv
// laser_rx_sampler
//   Receives byte frames from a photodiode line sampled on the base clock.
//   Frame on the line: idle 0, start bit 1, 8 data bits LSB first, stop bit 0.
//   Each bit lasts CLKS_PER_BIT base-clock cycles. The receiver samples each bit
//   near its middle, counting from the first cycle in which the synchronized
//   line is seen high.
//
// Parameters
//   CLKS_PER_BIT  base-clock cycles per laser bit (even, 4..254)
//
// Ports
//   clock        in   base clock; every flop in this block uses it
//   reset        in   asynchronous, active-high reset
//   en           in   receiver enable; low forces IDLE on the next edge
//   laser_rx     in   raw photodiode line (asynchronous, 1 = light)
//   data_valid   out  one-cycle pulse when a good frame has been received
//   data_in      out  last good byte, held until the next good frame
//   frame_err    out  one-cycle pulse when a frame ends with a bad stop bit
//   busy         out  high whenever the receiver is not in IDLE
//   frame_count  out  count of good frames, wraps at 16 bits
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a 0->1 transition of the synchronized line
// START     | timing to the middle of the start bit to confirm it
// DATA      | sampling the 8 data bits, LSB first
// STOP      | timing to the middle of the stop bit, judging the frame
// WAIT_IDLE | bad frame seen; waiting for a full bit time of quiet line

module laser_rx_sampler #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        laser_rx,
  output logic        data_valid,
  output logic [7:0]  data_in,
  output logic        frame_err,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  // The FSM enters START one cycle after the first high cycle of rx_s (it
  // needs that cycle to see the edge), so the start-bit countdown is one
  // short of half a bit. After every sample the next one is a full bit away.
  localparam logic [7:0] HALF_LOAD = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] BIT_LOAD  = 8'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // Line synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic       sync1_q;
  logic       rx_s_q;
  logic       rx_prev_q;
  logic [1:0] arm_q;
  logic       start_edge;

  // arm_q counts the first cycles after reset. Until the synchronizer and the
  // edge-detect flop both hold real line samples, the 0 they were reset to
  // would make a line held high through reset look like a fresh rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      rx_s_q    <= 1'b0;
      rx_prev_q <= 1'b0;
      arm_q     <= 2'd0;
    end else begin
      sync1_q   <= laser_rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      if (arm_q != 2'd3) begin
        arm_q <= arm_q + 2'd1;
      end
    end
  end

  assign start_edge = (arm_q == 2'd3) && rx_s_q && !rx_prev_q;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [2:0]  state_q,       state_d;
  logic [7:0]  cyc_cnt_q,     cyc_cnt_d;
  logic [3:0]  bit_cnt_q,     bit_cnt_d;
  logic [7:0]  shift_q,       shift_d;
  logic [7:0]  data_in_q,     data_in_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        data_valid_q,  data_valid_d;
  logic        frame_err_q,   frame_err_d;
  logic        cyc_tc;

  assign cyc_tc = (cyc_cnt_q == 8'd0);

  always_comb begin
    state_d       = state_q;
    cyc_cnt_d     = cyc_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_in_d     = data_in_q;
    frame_count_d = frame_count_q;
    data_valid_d  = 1'b0;
    frame_err_d   = 1'b0;

    if (!en) begin
      // Partial byte is simply abandoned; the shift register is not cleared
      // because data_in only ever loads from it on a good stop bit.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_d   = S_START;
            cyc_cnt_d = HALF_LOAD;
            bit_cnt_d = 4'd0;
          end
        end

        S_START: begin
          if (cyc_tc) begin
            if (rx_s_q) begin
              state_d   = S_DATA;
              cyc_cnt_d = BIT_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cyc_cnt_d = cyc_cnt_q - 8'd1;
          end
        end

        S_DATA: begin
          if (cyc_tc) begin
            // Shift right so the first (LSB) bit ends up in position 0.
            shift_d   = {rx_s_q, shift_q[7:1]};
            cyc_cnt_d = BIT_LOAD;
            if (bit_cnt_q == 4'd7) begin
              state_d = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            cyc_cnt_d = cyc_cnt_q - 8'd1;
          end
        end

        S_STOP: begin
          if (cyc_tc) begin
            if (!rx_s_q) begin
              state_d       = S_IDLE;
              data_in_d     = shift_q;
              data_valid_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              state_d     = S_WAIT_IDLE;
              frame_err_d = 1'b1;
              cyc_cnt_d   = BIT_LOAD;
            end
          end else begin
            cyc_cnt_d = cyc_cnt_q - 8'd1;
          end
        end

        S_WAIT_IDLE: begin
          // Any light restarts the quiet-time countdown.
          if (rx_s_q) begin
            cyc_cnt_d = BIT_LOAD;
          end else if (cyc_tc) begin
            state_d = S_IDLE;
          end else begin
            cyc_cnt_d = cyc_cnt_q - 8'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cyc_cnt_q     <= 8'd0;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      data_in_q     <= 8'h00;
      frame_count_q <= 16'h0000;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_cnt_q     <= cyc_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_in_q     <= data_in_d;
      frame_count_q <= frame_count_d;
      data_valid_q  <= data_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // data_in is loaded on the same edge that raises data_valid and does not
  // change again until the next good frame, so it is stable for the pulse.
  assign data_valid  = data_valid_q;
  assign data_in     = data_in_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_laser_rx_sampler.sv
// tb_laser_rx_sampler
//   Directed bench for laser_rx_sampler with CLKS_PER_BIT = 4. Inputs change
//   1 ns after a rising edge; outputs are read 1 ns after a rising edge.
//   Pulse events are logged by a monitor and compared against expected cycles.

module tb_laser_rx_sampler;

  localparam int B   = 4;
  localparam int LAT = 2 + B / 2 + 9 * B + 1;   // 41 cycles for B = 4
  localparam int FRM = 10 * B;                  // cycles per frame on the line

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic        laser_rx;
  logic        data_valid;
  logic [7:0]  data_in;
  logic        frame_err;
  logic        busy;
  logic [15:0] frame_count;

  always #10 clock = ~clock;

  laser_rx_sampler #(.CLKS_PER_BIT(B)) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .laser_rx    (laser_rx),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .frame_err   (frame_err),
    .busy        (busy),
    .frame_count (frame_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  int         dv_cyc[$];
  logic [7:0] dv_dat[$];
  logic [15:0] dv_cnt[$];
  int         fe_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Monitor: log every output pulse with its cycle number.
  always @(posedge clock) begin
    cyc_n <= cyc_n + 1;
    #1;
    if (data_valid) begin
      dv_cyc.push_back(cyc_n);
      dv_dat.push_back(data_in);
      dv_cnt.push_back(frame_count);
    end
    if (frame_err) begin
      fe_cyc.push_back(cyc_n);
    end
    if (data_valid || frame_err) begin
      check("dv_fe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    laser_rx = v;
    tick(B);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc_n;
    drive_bit(1'b1);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stop);
  endtask

  task automatic expect_dv(input string tag, input int idx, input int exp_cyc,
                           input logic [7:0] exp_dat, input logic [15:0] exp_cnt);
    if (idx < dv_cyc.size()) begin
      check({tag, "_cycle"}, dv_cyc[idx], exp_cyc);
      check({tag, "_data"},  {24'd0, dv_dat[idx]}, {24'd0, exp_dat});
      check({tag, "_count"}, {16'd0, dv_cnt[idx]}, {16'd0, exp_cnt});
    end else begin
      check({tag, "_present"}, dv_cyc.size(), idx + 1);
    end
  endtask

  task automatic clear_log();
    dv_cyc.delete();
    dv_dat.delete();
    dv_cnt.delete();
    fe_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, g;
    logic [15:0] exp_cnt;
    exp_cnt = 16'h0000;

    // Reset with the line held high: reset values, then no false start.
    reset = 1'b1; en = 1'b1; laser_rx = 1'b1;
    tick(3);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_frame_err",  {31'd0, frame_err}, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd0);
    check("rst_data_in",    {24'd0, data_in}, 32'h00);
    check("rst_frame_count", {16'd0, frame_count}, 32'h0000);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("busy_line_high_after_rst", {31'd0, busy}, 32'd0);
    end
    laser_rx = 1'b0;
    tick(6);
    check("no_pulse_after_rst", dv_cyc.size() + fe_cyc.size(), 0);
    clear_log();

    // Single frame 0xA5: latency and content.
    send_frame(8'hA5, 1'b0, t0);
    tick(5);
    exp_cnt = exp_cnt + 16'd1;
    check("a5_pulses", dv_cyc.size(), 1);
    expect_dv("a5", 0, t0 + LAT, 8'hA5, exp_cnt);
    check("a5_no_err", fe_cyc.size(), 0);
    clear_log();

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, t0);
    send_frame(8'hFF, 1'b0, t1);
    send_frame(8'h3C, 1'b0, t2);
    tick(5);
    check("b2b_pulses", dv_cyc.size(), 3);
    exp_cnt = exp_cnt + 16'd1;
    expect_dv("b2b0", 0, t0 + LAT, 8'h00, exp_cnt);
    exp_cnt = exp_cnt + 16'd1;
    expect_dv("b2b1", 1, t0 + LAT + FRM, 8'hFF, exp_cnt);
    exp_cnt = exp_cnt + 16'd1;
    expect_dv("b2b2", 2, t0 + LAT + 2 * FRM, 8'h3C, exp_cnt);
    check("b2b_no_err", fe_cyc.size(), 0);
    clear_log();

    // One-cycle glitch: false start, back to idle quickly.
    g = cyc_n;
    laser_rx = 1'b1;
    tick(1);
    laser_rx = 1'b0;
    tick(2);
    check("glitch_start_seen", {31'd0, busy}, 32'd1);
    tick(2);
    check("glitch_idle_by_5", {31'd0, busy}, 32'd0);
    tick(5);
    check("glitch_no_pulse", dv_cyc.size() + fe_cyc.size(), 0);
    check("glitch_data_held", {24'd0, data_in}, 32'h3C);
    clear_log();

    // Bad stop bit, line then held high 20 cycles.
    send_frame(8'h5A, 1'b1, t0);
    tick(20);
    laser_rx = 1'b0;
    tick(5);
    check("wait_idle_held", {31'd0, busy}, 32'd1);
    tick(1);
    check("wait_idle_released", {31'd0, busy}, 32'd0);
    check("bad_err_pulses", fe_cyc.size(), 1);
    if (fe_cyc.size() == 1) check("bad_err_cycle", fe_cyc[0], t0 + LAT);
    check("bad_no_valid", dv_cyc.size(), 0);
    check("bad_data_held", {24'd0, data_in}, 32'h3C);
    check("bad_count_held", {16'd0, frame_count}, {16'd0, exp_cnt});
    clear_log();
    send_frame(8'h11, 1'b0, t0);
    tick(5);
    exp_cnt = exp_cnt + 16'd1;
    check("after_bad_pulses", dv_cyc.size(), 1);
    expect_dv("after_bad", 0, t0 + LAT, 8'h11, exp_cnt);
    clear_log();

    // Enable dropped during data bit 3.
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    laser_rx = 1'b1;
    tick(2);
    check("en_mid_frame_busy", {31'd0, busy}, 32'd1);
    en = 1'b0;
    tick(1);
    check("en_drop_idle", {31'd0, busy}, 32'd0);
    laser_rx = 1'b0;
    tick(8);
    en = 1'b1;
    tick(8);
    check("en_drop_no_pulse", dv_cyc.size() + fe_cyc.size(), 0);
    check("en_drop_data_held", {24'd0, data_in}, 32'h11);
    clear_log();
    send_frame(8'h81, 1'b0, t0);
    tick(5);
    exp_cnt = exp_cnt + 16'd1;
    check("after_en_pulses", dv_cyc.size(), 1);
    expect_dv("after_en", 0, t0 + LAT, 8'h81, exp_cnt);
    clear_log();

    // Reset mid-frame: immediate abort, no pulse afterwards.
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_data", {24'd0, data_in}, 32'h00);
    check("async_rst_count", {16'd0, frame_count}, 32'h0000);
    laser_rx = 1'b0;
    tick(2);
    reset = 1'b0;
    exp_cnt = 16'h0000;
    tick(50);
    check("rst_abort_no_pulse", dv_cyc.size() + fe_cyc.size(), 0);
    clear_log();

    // frame_count wrap.
    force dut.frame_count_q = 16'hFFFF;
    tick(1);
    release dut.frame_count_q;
    tick(1);
    check("preload_count", {16'd0, frame_count}, 32'hFFFF);
    exp_cnt = 16'hFFFF;
    send_frame(8'h42, 1'b0, t0);
    tick(5);
    exp_cnt = exp_cnt + 16'd1;
    check("wrap_pulses", dv_cyc.size(), 1);
    expect_dv("wrap", 0, t0 + LAT, 8'h42, exp_cnt);
    check("wrap_count_now", {16'd0, frame_count}, 32'h0000);
    clear_log();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/laser_rx_sampler.md
LASER_RX_SAMPLER -- requirements
Module: laser_rx_sampler

Interface
- REQ-001 SHALL have parameter CLKS_PER_BIT, default 4; meaning: base-clock cycles per laser bit; legal range even integers 4..254.
- REQ-002 SHALL have port clock, input, 1; meaning: 50 MHz base clock, and all logic SHALL be in this domain.
- REQ-003 SHALL have port reset, input, 1; meaning: asynchronous, active-high reset.
- REQ-004 SHALL have port en, input, 1; meaning: receiver enable.
- REQ-005 SHALL have port laser_rx, input, 1; meaning: raw photodiode line, asynchronous, where 1 = light.
- REQ-006 SHALL have port data_valid, output, 1; meaning: one-cycle pulse when a good frame is received.
- REQ-007 SHALL have port data_in, output, 8; meaning: last good byte, held until the next good frame.
- REQ-008 SHALL have port frame_err, output, 1; meaning: one-cycle pulse on a bad stop bit.
- REQ-009 SHALL have port busy, output, 1; meaning: high whenever state is not IDLE.
- REQ-010 SHALL have port frame_count, output, 16; meaning: count of good frames, wrapping.

Function
- REQ-011 SHALL synchronize laser_rx through two flops into rx_s; all decisions use rx_s only.
- REQ-012 SHALL use frame format: idle 0; start bit 1; 8 data bits, LSB first; stop bit 0.
- REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
- REQ-014 IDLE: a 0->1 transition of rx_s while en=1 SHALL enter START with the bit counter cleared; call that cycle T0.
- REQ-015 START: at T0+CLKS_PER_BIT/2, rx_s=1 SHALL enter DATA; rx_s=0 SHALL return to IDLE, a false start, with no pulse.
- REQ-016 DATA: data bit k (k=0..7) SHALL be sampled at T0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT and shifted into bit position k.
- REQ-017 DATA SHALL enter STOP after bit 7 is sampled.
- REQ-018 STOP: the sample at T0+CLKS_PER_BIT/2+9*CLKS_PER_BIT SHALL be taken; rx_s=0 is a good frame, rx_s=1 is a bad frame.
- REQ-019 Good frame: on the cycle after the stop sample, the design SHALL load data_in, pulse data_valid for exactly 1 cycle, increment frame_count, and return to IDLE.
- REQ-020 Bad frame: on the cycle after the stop sample, the design SHALL pulse frame_err for 1 cycle, leave data_in and frame_count unchanged, and enter WAIT_IDLE.
- REQ-021 WAIT_IDLE SHALL return to IDLE only after rx_s has been 0 for CLKS_PER_BIT consecutive cycles.
- REQ-022 Total latency SHALL be: data_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the laser_rx edge; for CLKS_PER_BIT=4 this is 41 cycles.
- REQ-023 Cycle counter width SHALL be 8 bits and bit counter width 4 bits; neither counter SHALL wrap within a frame.
- REQ-024 frame_count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
- REQ-025 en deasserted in any state SHALL force IDLE on the next edge, with the partial byte discarded and no pulse.
- REQ-026 A new start SHALL be accepted on the first IDLE cycle after a good frame, so back-to-back frames with no idle gap beyond the stop bit are received.
- REQ-027 data_valid and frame_err SHALL never be asserted in the same cycle.
- REQ-028 data_valid SHALL be compatible with direct connection to an FTDI write-queue wrreq, with data_in stable while data_valid=1.

Reset
- REQ-029 Reset SHALL set state=IDLE, both synchronizer flops=0, shift register=0, data_in=8'h00, frame_count=16'h0000, and data_valid=frame_err=busy=0.
- REQ-030 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) and produce no pulse after release.
- REQ-031 A line held at 1 through reset release SHALL NOT be taken as a start, because only a 0->1 transition of rx_s starts a frame.

Verification
- REQ-032 SHALL cover: with en=1 and CLKS_PER_BIT=4, send frame 0xA5 -> data_valid for 1 cycle 41 cycles after the start edge, data_in=8'hA5, frame_count=1.
- REQ-033 SHALL cover: send 0x00, 0xFF, 0x3C back-to-back -> three data_valid pulses spaced 40 cycles apart with matching data_in, frame_count=3.
- REQ-034 SHALL cover: a 1-cycle glitch high on laser_rx -> no pulse, busy returns to 0 within 5 cycles, data_in unchanged.
- REQ-035 SHALL cover: frame 0x5A with stop bit 1, then the line held high 20 cycles -> frame_err pulse, data_in unchanged, busy held until 4 zero cycles, next good 0x11 received.
- REQ-036 SHALL cover: en dropped during data bit 3, then raised -> no pulse; the following frame 0x81 is received correctly.
- REQ-037 SHALL cover: preload frame_count to 16'hFFFF via 65535 frames, or by force, then one good frame -> frame_count=16'h0000.
